// File: rtl/tcm_stream_loader_pkg.sv
// Shared definitions for the TCM stream boot loader.
//  - frame command codes
//  - FSM state encoding (CHK state only exists when LOADER_CHECKSUM_EN is defined)
//  - header byte count and bytes-per-word derivation
// Optional feature macro: LOADER_CHECKSUM_EN (8-bit payload checksum trailer).
package tcm_stream_loader_pkg;

  localparam logic [7:0] LDR_CMD_ITCM  = 8'h01;
  localparam logic [7:0] LDR_CMD_DTCM  = 8'h02;
  localparam logic [7:0] LDR_CMD_START = 8'h03;

  // ADDR_LO, ADDR_HI, CNT_LO, CNT_HI
  localparam int unsigned LDR_HDR_BYTES = 4;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERR     = 3'd5
  } ldr_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_RUN     = 3'd4,
    ST_ERR     = 3'd5
  } ldr_state_e;
`endif

  function automatic int unsigned ldr_bpw(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // States in which the loader consumes stream bytes.
  function automatic logic ldr_accepts(input ldr_state_e s);
`ifdef LOADER_CHECKSUM_EN
    return (s == ST_IDLE) || (s == ST_HDR) || (s == ST_PAYLOAD) || (s == ST_CHK);
`else
    return (s == ST_IDLE) || (s == ST_HDR) || (s == ST_PAYLOAD);
`endif
  endfunction

endpackage

// File: rtl/loader_word_pack.sv
// Little-endian byte-to-word packer for the TCM stream loader.
// Ports:
//  clk, rst_    clock, asynchronous active-low reset
//  clear        restart packing at a new frame (drops partial word, zeroes checksum)
//  byte_en      payload byte accepted this cycle
//  byte_in      payload byte
//  word_done    combinational: this byte completes a word
//  word         completed word (valid when word_done), first byte in bits [7:0]
//  sum          (LOADER_CHECKSUM_EN only) modulo-256 sum of bytes since clear
module loader_word_pack
  import tcm_stream_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic              word_done,
  output logic [DATA_W-1:0] word
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        sum
`endif
);

  localparam int unsigned BPW = ldr_bpw(DATA_W);
  localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0]     byte_cnt;
  logic [DATA_W-1:0] word_q;

  assign word_done = byte_en && (byte_cnt == CW'(BPW - 1));

  // Bytes land in their final lane; the lane being written this cycle is
  // bypassed so the word is complete in the same cycle as its last byte.
  always_comb begin
    word = word_q;
    for (int unsigned i = 0; i < BPW; i++) begin
      if (byte_cnt == CW'(i)) word[i*8 +: 8] = byte_in;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      byte_cnt <= '0;
      word_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else if (clear) begin
      byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else if (byte_en) begin
      for (int unsigned i = 0; i < BPW; i++) begin
        if (byte_cnt == CW'(i)) word_q[i*8 +: 8] <= byte_in;
      end
      byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum      <= sum + byte_in;
`endif
    end
  end

endmodule

// File: rtl/tcm_stream_loader.sv
// TCM stream boot loader: parses framed byte-stream commands, packs payload
// bytes into DATA_W words and writes them into ITCM or DTCM, then releases
// the core with cpu_start.
// Frame: CMD, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, CNT*BPW payload bytes
//        [+ checksum byte when LOADER_CHECKSUM_EN is defined and CNT != 0].
// Ports:
//  clk, rst_            clock, asynchronous active-low reset
//  in_valid/in_ready    byte stream handshake, in_data the byte
//  itcm_we/itcm_addr    ITCM word write strobe and address
//  dtcm_we/dtcm_addr    DTCM word write strobe and address
//  tcm_wdata            write data shared by both TCMs
//  cpu_start            level, high once a START frame is accepted
//  busy                 frame in progress
//  error                sticky error (illegal command or checksum mismatch)
// Optional feature macro: LOADER_CHECKSUM_EN.
module tcm_stream_loader
  import tcm_stream_loader_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned I_ADDR_W = 10,
  parameter int unsigned D_ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  output logic                itcm_we,
  output logic [I_ADDR_W-1:0] itcm_addr,
  output logic                dtcm_we,
  output logic [D_ADDR_W-1:0] dtcm_addr,
  output logic [DATA_W-1:0]   tcm_wdata,
  output logic                cpu_start,
  output logic                busy,
  output logic                error
);

  ldr_state_e state, next_state;

  logic        accept;
  logic        is_load_cmd;
  logic [1:0]  hdr_cnt;
  logic        is_dtcm;
  logic [15:0] base;
  logic [15:0] cnt;
  logic [15:0] widx;
  logic        last_word;
  logic        pack_clear;
  logic        pack_en;
  logic        word_done;
  logic [DATA_W-1:0] word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  assign accept      = in_valid && in_ready;
  assign is_load_cmd = (in_data == LDR_CMD_ITCM) || (in_data == LDR_CMD_DTCM);
  assign last_word   = ((widx + 16'd1) == cnt);

  loader_word_pack #(
    .DATA_W (DATA_W)
  ) u_pack (
    .clk       (clk),
    .rst_      (rst_),
    .clear     (pack_clear),
    .byte_en   (pack_en),
    .byte_in   (in_data),
    .word_done (word_done),
    .word      (word)
`ifdef LOADER_CHECKSUM_EN
    ,
    .sum       (sum)
`endif
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pack_clear = 1'b0;
    pack_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_load_cmd) begin
            next_state = ST_HDR;
            pack_clear = 1'b1;
          end else if (in_data == LDR_CMD_START) begin
            next_state = ST_RUN;
          end else begin
            next_state = ST_ERR;
          end
        end
      end
      ST_HDR: begin
        if (accept && (hdr_cnt == 2'(LDR_HDR_BYTES - 1))) begin
          // in_data is CNT_HI; CNT_LO was captured on the previous byte
          if ({in_data, cnt[7:0]} == 16'd0) next_state = ST_IDLE;
          else                              next_state = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        pack_en = accept;
        if (word_done && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = ST_CHK;
`else
          next_state = ST_IDLE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) next_state = (in_data == sum) ? ST_IDLE : ST_ERR;
      end
`endif
      ST_RUN:  next_state = ST_RUN;
      ST_ERR:  next_state = ST_ERR;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      in_ready  <= 1'b0;
      itcm_we   <= 1'b0;
      dtcm_we   <= 1'b0;
      itcm_addr <= '0;
      dtcm_addr <= '0;
      tcm_wdata <= '0;
      hdr_cnt   <= '0;
      is_dtcm   <= 1'b0;
      base      <= '0;
      cnt       <= '0;
      widx      <= '0;
    end else begin
      // Registered so it stays low throughout reset and tracks the state entered.
      in_ready <= ldr_accepts(next_state);
      itcm_we  <= 1'b0;
      dtcm_we  <= 1'b0;

      if ((state == ST_IDLE) && accept && is_load_cmd) begin
        is_dtcm <= (in_data == LDR_CMD_DTCM);
        hdr_cnt <= '0;
      end

      if ((state == ST_HDR) && accept) begin
        case (hdr_cnt)
          2'd0: base[7:0]  <= in_data;
          2'd1: base[15:8] <= in_data;
          2'd2: cnt[7:0]   <= in_data;
          2'd3: cnt[15:8]  <= in_data;
          default: ;
        endcase
        hdr_cnt <= hdr_cnt + 2'd1;
        widx    <= '0;
      end

      if ((state == ST_PAYLOAD) && word_done) begin
        widx      <= widx + 16'd1;
        tcm_wdata <= word;
        // Address truncation to the TCM width gives the modulo wrap.
        if (is_dtcm) begin
          dtcm_we   <= 1'b1;
          dtcm_addr <= D_ADDR_W'(base + widx);
        end else begin
          itcm_we   <= 1'b1;
          itcm_addr <= I_ADDR_W'(base + widx);
        end
      end
    end
  end

  assign busy      = (state == ST_HDR) || (state == ST_PAYLOAD)
`ifdef LOADER_CHECKSUM_EN
                   || (state == ST_CHK)
`endif
                   ;
  assign cpu_start = (state == ST_RUN);
  assign error     = (state == ST_ERR);

endmodule
